// File: rtl/arp_tbl_pkg.sv
// Shared definitions for the ARP table access controller: register map,
// STATUS/CMD bit positions, FSM encoding and table entry field slices.
package arp_tbl_pkg;

  localparam int unsigned ENTRY_W = 96;

  // Register index = byte offset [4:2]
  localparam logic [2:0] REG_DATA0  = 3'd0;
  localparam logic [2:0] REG_DATA1  = 3'd1;
  localparam logic [2:0] REG_DATA2  = 3'd2;
  localparam logic [2:0] REG_ADDR   = 3'd3;
  localparam logic [2:0] REG_CMD    = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;
  localparam logic [2:0] REG_OPCNT  = 3'd6;

  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_TIMEOUT = 1;
  localparam int unsigned ST_DONE    = 2;
  localparam int unsigned ST_DROPPED = 3;

  localparam int unsigned CMD_RD = 0;
  localparam int unsigned CMD_WR = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned IP_LSB  = 0;
  localparam int unsigned IP_MSB  = 31;
  localparam int unsigned MAC_LSB = 32;
  localparam int unsigned MAC_MSB = 79;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_ACK = 2'd2
  } state_t;

  function automatic logic [31:0] entry_ip(input logic [ENTRY_W-1:0] e);
    return e[IP_MSB:IP_LSB];
  endfunction

  function automatic logic [47:0] entry_mac(input logic [ENTRY_W-1:0] e);
    return e[MAC_MSB:MAC_LSB];
  endfunction

endpackage

// File: rtl/arp_tbl_axil_regs.sv
// AXI4-Lite slave, address decode and register file for the ARP table
// access controller. Emits a registered start pulse on an accepted CMD write.
module arp_tbl_axil_regs
  import arp_tbl_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_TBL_ADDR_WIDTH   = 5
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   i_awaddr,
  input  logic                            i_awvalid,
  output logic                            o_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   i_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                            i_wvalid,
  output logic                            o_wready,
  output logic [1:0]                      o_bresp,
  output logic                            o_bvalid,
  input  logic                            i_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   i_araddr,
  input  logic                            i_arvalid,
  output logic                            o_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   o_rdata,
  output logic [1:0]                      o_rresp,
  output logic                            o_rvalid,
  input  logic                            i_rready,
  input  logic                            i_busy,
  input  logic                            i_op_done,
  input  logic                            i_op_timeout,
  input  logic                            i_rd_capture,
  input  logic [ENTRY_W-1:0]              i_rd_entry,
  output logic                            o_start,
  output logic                            o_start_wr,
  output logic [C_TBL_ADDR_WIDTH-1:0]     o_tbl_addr,
  output logic [ENTRY_W-1:0]              o_entry
);

  logic [31:0]                 r_data0, r_data1, r_data2, r_opcnt;
  logic [C_TBL_ADDR_WIDTH-1:0] r_addr;
  logic                        r_timeout, r_done, r_dropped;
  logic                        r_start, r_start_wr;
  logic                        r_bvalid, r_rvalid;
  logic [1:0]                  r_bresp;
  logic [31:0]                 r_rdata;

  logic       w_wr_fire, w_wr_in, w_wr_guard, w_wr_drop, w_wr_ok;
  logic [2:0] w_wr_idx, w_rd_idx;
  logic       w_rd_fire, w_rd_in;
  logic [31:0] w_rd_val, w_status;
  logic       w_unused;

  assign w_unused = ^{i_wstrb, i_awaddr[1:0], i_araddr[1:0]};

  assign w_wr_fire  = i_awvalid & i_wvalid & ~r_bvalid;
  assign w_wr_idx   = i_awaddr[4:2];
  assign w_wr_in    = (i_awaddr[C_S_AXI_ADDR_WIDTH-1:5] == '0);
  assign w_wr_guard = w_wr_in & (w_wr_idx <= REG_CMD);
  assign w_wr_drop  = w_wr_fire & w_wr_guard & i_busy;
  assign w_wr_ok    = w_wr_fire & w_wr_in & ~w_wr_drop;

  assign w_rd_fire = i_arvalid & ~r_rvalid;
  assign w_rd_idx  = i_araddr[4:2];
  assign w_rd_in   = (i_araddr[C_S_AXI_ADDR_WIDTH-1:5] == '0);

  assign o_awready  = w_wr_fire;
  assign o_wready   = w_wr_fire;
  assign o_bvalid   = r_bvalid;
  assign o_bresp    = r_bresp;
  assign o_arready  = w_rd_fire;
  assign o_rvalid   = r_rvalid;
  assign o_rdata    = r_rdata;
  assign o_rresp    = RESP_OKAY;
  assign o_start    = r_start;
  assign o_start_wr = r_start_wr;
  assign o_tbl_addr = r_addr;
  assign o_entry    = {r_data2, r_data1, r_data0};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_wr_fire) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_wr_drop ? RESP_SLVERR : RESP_OKAY;
    end else if (i_bready) begin
      r_bvalid <= 1'b0;
    end
  end

  // Read capture and register writes never coincide: writes are dropped while busy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data0 <= '0;
      r_data1 <= '0;
      r_data2 <= '0;
      r_addr  <= '0;
    end else if (i_rd_capture) begin
      r_data0 <= i_rd_entry[31:0];
      r_data1 <= i_rd_entry[63:32];
      r_data2 <= i_rd_entry[95:64];
    end else if (w_wr_ok) begin
      case (w_wr_idx)
        REG_DATA0: r_data0 <= i_wdata;
        REG_DATA1: r_data1 <= i_wdata;
        REG_DATA2: r_data2 <= i_wdata;
        REG_ADDR:  r_addr  <= i_wdata[C_TBL_ADDR_WIDTH-1:0];
        default:   ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_start    <= 1'b0;
      r_start_wr <= 1'b0;
    end else begin
      r_start <= w_wr_ok & (w_wr_idx == REG_CMD) & (i_wdata[CMD_RD] | i_wdata[CMD_WR]);
      if (w_wr_ok && (w_wr_idx == REG_CMD))
        r_start_wr <= i_wdata[CMD_WR];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timeout <= 1'b0;
      r_done    <= 1'b0;
      r_dropped <= 1'b0;
      r_opcnt   <= '0;
    end else begin
      if (w_wr_ok && (w_wr_idx == REG_STATUS)) begin
        r_timeout <= 1'b0;
        r_done    <= 1'b0;
        r_dropped <= 1'b0;
      end
      if (r_start)      r_done    <= 1'b0;
      if (i_op_done)    r_done    <= 1'b1;
      if (i_op_timeout) r_timeout <= 1'b1;
      if (w_wr_drop)    r_dropped <= 1'b1;
      if (i_op_done)    r_opcnt   <= r_opcnt + 32'd1;
    end
  end

  always_comb begin
    w_status             = '0;
    w_status[ST_BUSY]    = i_busy;
    w_status[ST_TIMEOUT] = r_timeout;
    w_status[ST_DONE]    = r_done;
    w_status[ST_DROPPED] = r_dropped;
    w_rd_val             = '0;
    if (w_rd_in) begin
      case (w_rd_idx)
        REG_DATA0:  w_rd_val = r_data0;
        REG_DATA1:  w_rd_val = r_data1;
        REG_DATA2:  w_rd_val = r_data2;
        REG_ADDR:   w_rd_val = {{(32-C_TBL_ADDR_WIDTH){1'b0}}, r_addr};
        REG_STATUS: w_rd_val = w_status;
        REG_OPCNT:  w_rd_val = r_opcnt;
        default:    w_rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else if (w_rd_fire) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_val;
    end else if (i_rready) begin
      r_rvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/arp_tbl_access_ctrl.sv
// CPU-side ARP table initiator: AXI-Lite registers drive one-cycle table
// req pulses and wait for the matching ack. Optional macro: ARP_TBL_TIMEOUT_EN.
module arp_tbl_access_ctrl
  import arp_tbl_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_TBL_ADDR_WIDTH   = 5,
  parameter int unsigned C_ACK_TIMEOUT      = 16
) (
  input  logic                            AXI_ACLK,
  input  logic                            AXI_RESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            tbl_wr_req,
  output logic                            tbl_rd_req,
  output logic [C_TBL_ADDR_WIDTH-1:0]     tbl_wr_addr,
  output logic [C_TBL_ADDR_WIDTH-1:0]     tbl_rd_addr,
  output logic [ENTRY_W-1:0]              tbl_wr_data,
  input  logic [ENTRY_W-1:0]              tbl_rd_data,
  input  logic                            tbl_wr_ack,
  input  logic                            tbl_rd_ack
);

  state_t r_state, w_next;

  logic                        r_op_wr;
  logic [C_TBL_ADDR_WIDTH-1:0] r_tbl_addr;
  logic [ENTRY_W-1:0]          r_tbl_wr_data;

  logic                        w_start, w_start_wr;
  logic [C_TBL_ADDR_WIDTH-1:0] w_reg_addr;
  logic [ENTRY_W-1:0]          w_reg_entry;
  logic w_issue, w_active, w_ack, w_op_done, w_op_timeout, w_rd_capture, w_busy;
  logic w_unused;

  assign w_unused = ^C_ACK_TIMEOUT;

  arp_tbl_axil_regs #(
    .C_S_AXI_DATA_WIDTH (C_S_AXI_DATA_WIDTH),
    .C_S_AXI_ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
    .C_TBL_ADDR_WIDTH   (C_TBL_ADDR_WIDTH)
  ) u_regs (
    .i_clk        (AXI_ACLK),
    .i_rst_n      (AXI_RESETN),
    .i_awaddr     (S_AXI_AWADDR),
    .i_awvalid    (S_AXI_AWVALID),
    .o_awready    (S_AXI_AWREADY),
    .i_wdata      (S_AXI_WDATA),
    .i_wstrb      (S_AXI_WSTRB),
    .i_wvalid     (S_AXI_WVALID),
    .o_wready     (S_AXI_WREADY),
    .o_bresp      (S_AXI_BRESP),
    .o_bvalid     (S_AXI_BVALID),
    .i_bready     (S_AXI_BREADY),
    .i_araddr     (S_AXI_ARADDR),
    .i_arvalid    (S_AXI_ARVALID),
    .o_arready    (S_AXI_ARREADY),
    .o_rdata      (S_AXI_RDATA),
    .o_rresp      (S_AXI_RRESP),
    .o_rvalid     (S_AXI_RVALID),
    .i_rready     (S_AXI_RREADY),
    .i_busy       (w_busy),
    .i_op_done    (w_op_done),
    .i_op_timeout (w_op_timeout),
    .i_rd_capture (w_rd_capture),
    .i_rd_entry   (tbl_rd_data),
    .o_start      (w_start),
    .o_start_wr   (w_start_wr),
    .o_tbl_addr   (w_reg_addr),
    .o_entry      (w_reg_entry)
  );

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) r_state <= S_IDLE;
    else             r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_start) w_next = S_ISSUE;
      S_ISSUE:    w_next = w_op_done ? S_IDLE : S_WAIT_ACK;
      S_WAIT_ACK: if (w_op_done || w_op_timeout) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Busy covers the pending start pulse so no register write slips in before ISSUE
  always_comb begin
    w_issue      = (r_state == S_ISSUE);
    w_active     = w_issue | (r_state == S_WAIT_ACK);
    w_ack        = r_op_wr ? tbl_wr_ack : tbl_rd_ack;
    w_op_done    = w_active & w_ack;
    w_rd_capture = w_op_done & ~r_op_wr;
    w_busy       = (r_state != S_IDLE) | w_start;
    tbl_wr_req   = w_issue & r_op_wr;
    tbl_rd_req   = w_issue & ~r_op_wr;
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      r_op_wr       <= 1'b0;
      r_tbl_addr    <= '0;
      r_tbl_wr_data <= '0;
    end else if ((r_state == S_IDLE) && w_start) begin
      r_op_wr       <= w_start_wr;
      r_tbl_addr    <= w_reg_addr;
      r_tbl_wr_data <= w_reg_entry;
    end
  end

  assign tbl_wr_addr = r_tbl_addr;
  assign tbl_rd_addr = r_tbl_addr;
  assign tbl_wr_data = r_tbl_wr_data;

`ifdef ARP_TBL_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(C_ACK_TIMEOUT) + 1;
  logic [TO_W-1:0] r_to_cnt;

  // The ISSUE cycle counts as the first ack-less cycle
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN)                  r_to_cnt <= '0;
    else if (r_state == S_ISSUE)      r_to_cnt <= TO_W'(1);
    else if (r_state == S_WAIT_ACK)   r_to_cnt <= r_to_cnt + TO_W'(1);
  end

  assign w_op_timeout = (r_state == S_WAIT_ACK) & ~w_ack &
                        (r_to_cnt == TO_W'(C_ACK_TIMEOUT - 1));
`else
  assign w_op_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_arp_tbl_access_ctrl.sv
// Directed self-checking bench for arp_tbl_access_ctrl (vector table plus
// hand-written multi-cycle sequences).
module tb_arp_tbl_access_ctrl;
  import arp_tbl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = 4'hF;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        tbl_wr_req, tbl_rd_req;
  logic [4:0]  tbl_wr_addr, tbl_rd_addr;
  logic [95:0] tbl_wr_data;
  logic [95:0] tbl_rd_data = '0;
  logic        tbl_wr_ack = 1'b0, tbl_rd_ack = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  arp_tbl_access_ctrl dut (
    .AXI_ACLK      (clk),
    .AXI_RESETN    (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .tbl_wr_req    (tbl_wr_req),
    .tbl_rd_req    (tbl_rd_req),
    .tbl_wr_addr   (tbl_wr_addr),
    .tbl_rd_addr   (tbl_rd_addr),
    .tbl_wr_data   (tbl_wr_data),
    .tbl_rd_data   (tbl_rd_data),
    .tbl_wr_ack    (tbl_wr_ack),
    .tbl_rd_ack    (tbl_rd_ack)
  );

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [1:0]  exp_bresp;
    logic [31:0] raddr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [0:8];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: handshake did not complete within 20 cycles", name);
  endtask

  // All bus tasks start and end 1 time unit after a rising edge.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input int unsigned hold, output logic [1:0] resp);
    bit ok;
    resp = 2'bxx;
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (awready && wready) ok = 1'b1;
      @(posedge clk); #1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!ok) timeout_fail("aw_w_ready");
    repeat (hold) begin @(posedge clk); #1; end
    if (hold > 0) begin
      @(negedge clk);
      check("bvalid_held", 96'(bvalid), 96'd1);
      @(posedge clk); #1;
    end
    bready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bvalid) begin ok = 1'b1; resp = bresp; end
      @(posedge clk); #1;
    end
    bready = 1'b0;
    if (!ok) timeout_fail("bvalid");
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
    bit ok;
    d = 'x;
    araddr = a; arvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (arready) ok = 1'b1;
      @(posedge clk); #1;
    end
    arvalid = 1'b0;
    if (!ok) timeout_fail("arready");
    rready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rvalid) begin ok = 1'b1; d = rdata; check("rresp", 96'(rresp), 96'd0); end
      @(posedge clk); #1;
    end
    rready = 1'b0;
    if (!ok) timeout_fail("rvalid");
  endtask

  task automatic wr_chk(input string name, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] exp);
    logic [1:0] r;
    axi_write(a, d, 0, r);
    check(name, 96'(r), 96'(exp));
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    axi_read(a, r);
    check(name, 96'(r), 96'(exp));
  endtask

  task automatic cmd_write(input logic [31:0] d);
    logic [1:0] r;
    axi_write(32'h10, d, 0, r);
    check("cmd_bresp", 96'(r), 96'd0);
  endtask

  task automatic pulse_wr_ack();
    tbl_wr_ack = 1'b1; @(posedge clk); #1; tbl_wr_ack = 1'b0;
  endtask

  task automatic pulse_rd_ack();
    tbl_rd_ack = 1'b1; @(posedge clk); #1; tbl_rd_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0] r;

    vecs[0] = '{32'h00, 32'h12345678, 2'b00, 32'h00, 32'h12345678};
    vecs[1] = '{32'h04, 32'hDEADBEEF, 2'b00, 32'h04, 32'hDEADBEEF};
    vecs[2] = '{32'h08, 32'hCAFEF00D, 2'b00, 32'h08, 32'hCAFEF00D};
    vecs[3] = '{32'h0C, 32'hFFFFFFFF, 2'b00, 32'h0C, 32'h0000001F};
    vecs[4] = '{32'h10, 32'h00000000, 2'b00, 32'h10, 32'h00000000};
    vecs[5] = '{32'h1C, 32'hFFFFFFFF, 2'b00, 32'h1C, 32'h00000000};
    vecs[6] = '{32'h18, 32'hFFFFFFFF, 2'b00, 32'h18, 32'h00000000};
    vecs[7] = '{32'h14, 32'hFFFFFFFF, 2'b00, 32'h14, 32'h00000000};
    vecs[8] = '{32'h40, 32'h00000001, 2'b00, 32'h00, 32'h12345678};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          96'({awready, wready, arready, bvalid, rvalid, tbl_wr_req, tbl_rd_req, bresp, rresp}),
          96'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd_chk("reset_status", 32'h14, 32'h0);
    rd_chk("reset_opcnt",  32'h18, 32'h0);
    rd_chk("reset_data0",  32'h00, 32'h0);
    rd_chk("reset_addr",   32'h0C, 32'h0);

    // Register map vectors
    for (int i = 0; i < 9; i++) begin
      axi_write(vecs[i].waddr, vecs[i].wdata, 0, r);
      check($sformatf("vec%0d_bresp", i), 96'(r), 96'(vecs[i].exp_bresp));
      rd_chk($sformatf("vec%0d_rdata", i), vecs[i].raddr, vecs[i].exp_rdata);
    end

    // BVALID holds until BREADY
    axi_write(32'h04, 32'h0BADF00D, 3, r);
    check("hold_bresp", 96'(r), 96'd0);

    // Table write
    wr_chk("t1_d0", 32'h00, 32'h0A000001, 2'b00);
    wr_chk("t1_d1", 32'h04, 32'hBBCCDDEE, 2'b00);
    wr_chk("t1_d2", 32'h08, 32'h0000AABB, 2'b00);
    wr_chk("t1_ad", 32'h0C, 32'd3, 2'b00);
    cmd_write(32'h2);
    @(negedge clk);
    check("t1_wr_req", 96'({tbl_wr_req, tbl_rd_req}), 96'b10);
    check("t1_wr_addr", 96'(tbl_wr_addr), 96'd3);
    check("t1_wr_data", tbl_wr_data, 96'h0000AABB_BBCCDDEE_0A000001);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_req_one_cycle", 96'({tbl_wr_req, tbl_rd_req}), 96'b00);
    @(posedge clk); #1;
    pulse_wr_ack();
    rd_chk("t1_status", 32'h14, 32'h4);
    rd_chk("t1_opcnt",  32'h18, 32'd1);

    // Table read, with a non-matching ack first
    wr_chk("t2_ad", 32'h0C, 32'd7, 2'b00);
    cmd_write(32'h1);
    @(negedge clk);
    check("t2_rd_req", 96'({tbl_wr_req, tbl_rd_req}), 96'b01);
    check("t2_rd_addr", 96'(tbl_rd_addr), 96'd7);
    @(posedge clk); #1;
    pulse_wr_ack();
    rd_chk("t2_status_busy", 32'h14, 32'h1);
    tbl_rd_data = 96'hFFFFFFFF_FFFFFFFF_C0A80101;
    pulse_rd_ack();
    tbl_rd_data = '0;
    rd_chk("t2_data0",  32'h00, entry_ip(96'hFFFFFFFF_FFFFFFFF_C0A80101));
    rd_chk("t2_data1",  32'h04, 32'hFFFFFFFF);
    rd_chk("t2_data2",  32'h08, 32'hFFFFFFFF);
    rd_chk("t2_status", 32'h14, 32'h4);
    rd_chk("t2_opcnt",  32'h18, 32'd2);

    // Both CMD bits: write only, acked in the req cycle
    wr_chk("t3_ad", 32'h0C, 32'd9, 2'b00);
    cmd_write(32'h3);
    tbl_wr_ack = 1'b1;
    @(negedge clk);
    check("t3_req", 96'({tbl_wr_req, tbl_rd_req}), 96'b10);
    check("t3_wr_addr", 96'(tbl_wr_addr), 96'd9);
    check("t3_wr_data", tbl_wr_data, 96'hFFFFFFFF_FFFFFFFF_C0A80101);
    @(posedge clk); #1;
    tbl_wr_ack = 1'b0;
    @(negedge clk);
    check("t3_no_req_after", 96'({tbl_wr_req, tbl_rd_req}), 96'b00);
    @(posedge clk); #1;
    rd_chk("t3_status", 32'h14, 32'h4);
    rd_chk("t3_opcnt",  32'h18, 32'd3);

    // Writes while busy are dropped
    wr_chk("t4_ad", 32'h0C, 32'd2, 2'b00);
    cmd_write(32'h2);
    wr_chk("t4_drop_d0",  32'h00, 32'h11111111, 2'b10);
    wr_chk("t4_drop_cmd", 32'h10, 32'h1, 2'b10);
    wr_chk("t4_drop_ad",  32'h0C, 32'h1F, 2'b10);
    rd_chk("t4_data0",  32'h00, 32'hC0A80101);
    rd_chk("t4_addr",   32'h0C, 32'd2);
    rd_chk("t4_status", 32'h14, 32'h9);
    pulse_wr_ack();
    rd_chk("t4_status_done", 32'h14, 32'hC);
    wr_chk("t4_clr", 32'h14, 32'h0, 2'b00);
    rd_chk("t4_status_clr", 32'h14, 32'h0);
    rd_chk("t4_opcnt", 32'h18, 32'd4);

`ifdef ARP_TBL_TIMEOUT_EN
    // Timeout: status flips exactly 16 cycles after the req cycle
    tbl_rd_data = 96'h1;
    wr_chk("t5_ad", 32'h0C, 32'd5, 2'b00);
    cmd_write(32'h1);
    @(negedge clk);
    check("t5_rd_req", 96'(tbl_rd_req), 96'd1);
    repeat (15) @(posedge clk);
    #1;
    rd_chk("t5_status_c15", 32'h14, 32'h1);
    rd_chk("t5_status_after", 32'h14, 32'h2);
    wr_chk("t5_clr", 32'h14, 32'h0, 2'b00);
    cmd_write(32'h1);
    @(negedge clk);
    repeat (16) @(posedge clk);
    #1;
    rd_chk("t5_status_c16", 32'h14, 32'h2);
    rd_chk("t5_opcnt", 32'h18, 32'd4);
    rd_chk("t5_data0", 32'h00, 32'hC0A80101);
    pulse_rd_ack();
    rd_chk("t5_opcnt_late", 32'h18, 32'd4);
    tbl_rd_data = '0;
`else
    // No timeout: WAIT_ACK holds indefinitely
    cmd_write(32'h1);
    repeat (40) @(posedge clk);
    #1;
    rd_chk("t5_status_wait", 32'h14, 32'h1);
    tbl_rd_data = 96'hFFFFFFFF_FFFFFFFF_C0A80101;
    pulse_rd_ack();
    tbl_rd_data = '0;
    rd_chk("t5_status", 32'h14, 32'h4);
    rd_chk("t5_opcnt",  32'h18, 32'd5);
`endif
    wr_chk("t5_clr_end", 32'h14, 32'h0, 2'b00);

    // Reset mid-operation, then a late ack
    cmd_write(32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_req_drop", 96'({tbl_wr_req, tbl_rd_req}), 96'b00);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pulse_wr_ack();
    @(negedge clk);
    check("t6_no_req", 96'({tbl_wr_req, tbl_rd_req}), 96'b00);
    @(posedge clk); #1;
    rd_chk("t6_status", 32'h14, 32'h0);
    rd_chk("t6_opcnt",  32'h18, 32'h0);
    rd_chk("t6_data0",  32'h00, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arp_tbl_access_ctrl.md
Name: arp_tbl_access_ctrl

Overview:
CPU-side initiator for the ARP table read/write port in the router output-port-lookup pcore. It exposes an AXI4-Lite register slave, turns register commands into single-cycle tbl_wr_req/tbl_rd_req pulses, and waits for tbl_wr_ack/tbl_rd_ack. Read results are captured back into the data registers. Table entry format is {MAC+pad[95:32], next-hop IP[31:0]}.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI-Lite data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 32, AXI-Lite address width; decode uses ADDR[4:2].
C_TBL_ADDR_WIDTH, 5, table index width (32 entries).
C_ACK_TIMEOUT, 16, cycles to wait for an ack after the req pulse (timeout feature only).

Ports:
AXI_ACLK  in  1  clock
AXI_RESETN  in  1  reset, asynchronous, active-low
S_AXI_AWADDR/AWVALID/AWREADY  in/in/out  32/1/1  write address channel
S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel; WSTRB ignored
S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel
S_AXI_ARADDR/ARVALID/ARREADY  in/in/out  32/1/1  read address channel
S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data channel
tbl_wr_req  out  1  one-cycle table write pulse
tbl_rd_req  out  1  one-cycle table read pulse
tbl_wr_addr  out  5  write index
tbl_rd_addr  out  5  read index
tbl_wr_data  out  96  entry to write
tbl_rd_data  in  96  entry read
tbl_wr_ack  in  1  write ack pulse
tbl_rd_ack  in  1  read ack pulse

Behaviour:
- Register map (byte offsets): 0x00 DATA0 = entry[31:0] (IP); 0x04 DATA1 = entry[63:32]; 0x08 DATA2 = entry[95:64]; 0x0C ADDR[4:0]; 0x10 CMD (write-only; bit0 = read, bit1 = write; reads as 0); 0x14 STATUS (RO: bit0 busy, bit1 timeout sticky, bit2 done sticky, bit3 dropped sticky); 0x18 OPCNT, a 32-bit count of completed ops that wraps. Offsets 0x1C and above: reads return 0 with OKAY, writes have no effect and return OKAY.
- STATUS bits 1–3 clear on a write of any value to 0x14.
- Reset values: all registers 0. AWREADY, WREADY, ARREADY, BVALID, RVALID, tbl_*_req are 0. BRESP and RRESP are 2'b00.
- AXI write: accepted in the single cycle where AWVALID and WVALID are both high and BVALID is 0. AWREADY and WREADY pulse together in that cycle. BVALID rises the next cycle and holds until BREADY.
- AXI read: ARREADY pulses when ARVALID is high and RVALID is 0. RDATA and RVALID follow the next cycle. RVALID holds until RREADY.
- FSM states: IDLE, ISSUE, WAIT_ACK.
- IDLE → ISSUE on a CMD write with bit0 or bit1 set. If both bits are set, only the write is performed.
  - On entry, latch op type, tbl address = ADDR, and tbl_wr_data = {DATA2, DATA1, DATA0}.
  - Set busy and clear done.
- ISSUE: assert the selected req for exactly one cycle, then go to WAIT_ACK.
- WAIT_ACK: on the matching ack, go to IDLE, clear busy, set done, and increment OPCNT.
  - For a read, also capture tbl_rd_data into DATA0..2 in that same cycle.
  - A non-matching ack is ignored.
- An ack arriving in ISSUE, same cycle as req, is accepted as completion.
- Any write to CMD, DATA0..2 or ADDR while busy is ignored, sets dropped, and returns BRESP=SLVERR (2'b10). Register reads are always allowed.
- Latency: CMD write accepted (cycle 0) → req high in cycle 2 → done visible in the cycle after the ack.
- Reset mid-operation: FSM returns to IDLE immediately and any req is deasserted. The table ack that may follow is ignored.

Optional Feature:
ARP_TBL_TIMEOUT_EN: when defined, a counter runs in WAIT_ACK. After C_ACK_TIMEOUT cycles with no ack, the FSM goes to IDLE, sets timeout, clears busy, leaves done clear, and does not increment OPCNT. A read timeout leaves DATA0..2 unchanged. When undefined, WAIT_ACK waits indefinitely and STATUS bit1 reads 0.

Decomposition:
- Shared package (arp_tbl_pkg):
  - register offset constants;
  - STATUS bit positions;
  - CMD bit positions;
  - FSM state encoding;
  - entry field slices (IP [31:0], MAC [79:32]).
- One natural sub-module, arp_tbl_axil_regs: the AXI-Lite handshake, address decode and register file. The top level holds the FSM and table port.

Test Plan:
- Write DATA0=0x0A000001, DATA1=0xBBCCDDEE, DATA2=0x0000AABB, ADDR=3, CMD=0x2 → one-cycle tbl_wr_req with tbl_wr_addr=3 and tbl_wr_data=0x0000AABB_BBCCDDEE_0A000001; ack → STATUS=0x4, OPCNT=1.
- ADDR=7, CMD=0x1, responder returns 0xFFFFFFFF_FFFFFFFF_C0A80101 → DATA0 reads 0xC0A80101 and DATA2 reads 0xFFFFFFFF.
- CMD=0x3 → only tbl_wr_req pulses; tbl_rd_req stays 0.
- Write DATA0 while busy (ack held off) → BRESP=2'b10, DATA0 unchanged, STATUS bit3=1; write to 0x14 clears it.
- With ARP_TBL_TIMEOUT_EN and no ack → exactly 16 cycles after req, STATUS bit1=1, busy=0, OPCNT unchanged.
- Assert AXI_RESETN low during WAIT_ACK, release, then deliver a late ack → STATUS=0 and OPCNT=0.
